// File: rtl/atm_ledger.sv
// Multi-account, multi-currency balance ledger: reads, withdrawals, deposits and
// atomic transfers through a valid/ready request port and a one-cycle response pulse.
module atm_ledger #(
    parameter int unsigned NUM_ACCOUNTS     = 10,
    parameter int unsigned NUM_CURRENCIES   = 5,
    parameter int unsigned BAL_WIDTH        = 16,
    parameter int unsigned AMT_WIDTH        = 11,
    parameter int unsigned RESET_BAL_USD    = 500,
    parameter int unsigned RESET_BAL_CRYPTO = 10,
    localparam int unsigned AW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1,
    localparam int unsigned CW = (NUM_CURRENCIES > 1) ? $clog2(NUM_CURRENCIES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [AW-1:0]        req_acc,
    input  logic [AW-1:0]        req_dst_acc,
    input  logic [CW-1:0]        req_cur,
    input  logic [AMT_WIDTH-1:0] req_amount,
    output logic                 rsp_valid,
    output logic [3:0]           rsp_status,
    output logic [BAL_WIDTH-1:0] rsp_balance
);

    localparam logic [1:0] OP_READ     = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_TRANSFER = 2'b11;

    localparam logic [3:0] ST_ACC_FOUND     = 4'b0001;
    localparam logic [3:0] ST_ACC_NOT_FOUND = 4'b0010;
    localparam logic [3:0] ST_AMT_VALID     = 4'b0101;
    localparam logic [3:0] ST_AMT_INVALID   = 4'b0110;
    localparam logic [3:0] ST_OVERFLOW      = 4'b1001;
    localparam logic [3:0] ST_SAME_ACC      = 4'b1010;
    localparam logic [3:0] ST_BAD_CURRENCY  = 4'b1011;

    localparam logic [AW:0] ACC_LIMIT = (AW + 1)'(NUM_ACCOUNTS);
    localparam logic [CW:0] CUR_LIMIT = (CW + 1)'(NUM_CURRENCIES);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOOKUP = 2'b01,
        COMMIT = 2'b10,
        RESP   = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [BAL_WIDTH-1:0] bal [NUM_ACCOUNTS][NUM_CURRENCIES];

    logic [1:0]           op_q;
    logic [AW-1:0]        acc_q;
    logic [AW-1:0]        dst_q;
    logic [CW-1:0]        cur_q;
    logic [AMT_WIDTH-1:0] amt_raw_q;
    logic [BAL_WIDTH-1:0] src_bal_q;
    logic [BAL_WIDTH-1:0] dst_bal_q;
    logic [BAL_WIDTH-1:0] amt_q;
    logic [3:0]           status_q;

    logic [BAL_WIDTH-1:0] src_rd;
    logic [BAL_WIDTH-1:0] dst_rd;
    logic [BAL_WIDTH-1:0] amt_ext;
    logic [BAL_WIDTH:0]   sum_ext;
    logic [3:0]           lk_status;
    logic                 acc_bad;
    logic                 dst_bad;
    logic                 cur_bad;
    logic                 is_wd;
    logic                 is_dep;
    logic                 is_xfer;
    logic                 commit_ok;
    logic [BAL_WIDTH-1:0] src_next;
    logic [BAL_WIDTH-1:0] dst_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; IDLE is the only state that accepts a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = COMMIT;
            COMMIT:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Guarded balance read; out-of-range indices read as zero
    always_comb begin
        src_rd = '0;
        dst_rd = '0;
        for (int unsigned a = 0; a < NUM_ACCOUNTS; a++) begin
            for (int unsigned c = 0; c < NUM_CURRENCIES; c++) begin
                if (acc_q == AW'(a) && cur_q == CW'(c)) src_rd = bal[a][c];
                if (dst_q == AW'(a) && cur_q == CW'(c)) dst_rd = bal[a][c];
            end
        end
    end

    // Status evaluation in LOOKUP, highest-priority error first
    always_comb begin
        is_wd     = (op_q == OP_WITHDRAW);
        is_dep    = (op_q == OP_DEPOSIT);
        is_xfer   = (op_q == OP_TRANSFER);
        acc_bad   = ({1'b0, acc_q} >= ACC_LIMIT);
        dst_bad   = ({1'b0, dst_q} >= ACC_LIMIT);
        cur_bad   = ({1'b0, cur_q} >= CUR_LIMIT);
        amt_ext   = BAL_WIDTH'(amt_raw_q);
        sum_ext   = {1'b0, (is_xfer ? dst_rd : src_rd)} + {1'b0, amt_ext};
        lk_status = (op_q == OP_READ) ? ST_ACC_FOUND : ST_AMT_VALID;
        if (acc_bad || (is_xfer && dst_bad)) begin
            lk_status = ST_ACC_NOT_FOUND;
        end else if (cur_bad) begin
            lk_status = ST_BAD_CURRENCY;
        end else if (is_xfer && (dst_q == acc_q)) begin
            lk_status = ST_SAME_ACC;
        end else if ((is_wd || is_xfer) && (amt_ext > src_rd)) begin
            lk_status = ST_AMT_INVALID;
        end else if ((is_dep || is_xfer) && sum_ext[BAL_WIDTH]) begin
            lk_status = ST_OVERFLOW;
        end
    end

    // Commit arithmetic on the values registered in LOOKUP
    always_comb begin
        commit_ok = (op_q != OP_READ) && (status_q == ST_AMT_VALID);
        src_next  = (op_q == OP_DEPOSIT) ? (src_bal_q + amt_q) : (src_bal_q - amt_q);
        dst_next  = dst_bal_q + amt_q;
    end

    // Request capture, lookup registers and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_status  <= 4'b0000;
            rsp_balance <= '0;
            op_q        <= OP_READ;
            acc_q       <= '0;
            dst_q       <= '0;
            cur_q       <= '0;
            amt_raw_q   <= '0;
            src_bal_q   <= '0;
            dst_bal_q   <= '0;
            amt_q       <= '0;
            status_q    <= 4'b0000;
        end else begin
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_op;
                        acc_q     <= req_acc;
                        dst_q     <= req_dst_acc;
                        cur_q     <= req_cur;
                        amt_raw_q <= req_amount;
                    end
                end
                LOOKUP: begin
                    src_bal_q <= src_rd;
                    dst_bal_q <= dst_rd;
                    amt_q     <= amt_ext;
                    status_q  <= lk_status;
                end
                COMMIT: begin
                    rsp_status  <= status_q;
                    rsp_balance <= commit_ok ? src_next : src_bal_q;
                end
                default: ;
            endcase
        end
    end

    // Balance storage; a transfer updates both accounts on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < NUM_ACCOUNTS; a++) begin
                for (int unsigned c = 0; c < NUM_CURRENCIES; c++) begin
                    bal[a][c] <= (c == 0) ? BAL_WIDTH'(RESET_BAL_USD)
                                          : BAL_WIDTH'(RESET_BAL_CRYPTO);
                end
            end
        end else if (state_q == COMMIT && commit_ok) begin
            for (int unsigned a = 0; a < NUM_ACCOUNTS; a++) begin
                for (int unsigned c = 0; c < NUM_CURRENCIES; c++) begin
                    if (acc_q == AW'(a) && cur_q == CW'(c)) begin
                        bal[a][c] <= src_next;
                    end else if (is_xfer && dst_q == AW'(a) && cur_q == CW'(c)) begin
                        bal[a][c] <= dst_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_ledger.sv
// Directed bench for atm_ledger (11-bit balances) with an expected-response queue.
module tb_atm_ledger;

    localparam int unsigned BW = 11;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [3:0]    req_acc;
    logic [3:0]    req_dst_acc;
    logic [2:0]    req_cur;
    logic [10:0]   req_amount;
    logic          rsp_valid;
    logic [3:0]    rsp_status;
    logic [BW-1:0] rsp_balance;

    int checks = 0;
    int errors = 0;
    bit got_rsp;
    logic [3+BW:0] exp_q[$];

    localparam logic [1:0] RD = 2'b00, WD = 2'b01, DP = 2'b10, XF = 2'b11;

    atm_ledger #(
        .NUM_ACCOUNTS(10), .NUM_CURRENCIES(5), .BAL_WIDTH(BW), .AMT_WIDTH(11),
        .RESET_BAL_USD(500), .RESET_BAL_CRYPTO(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_acc(req_acc), .req_dst_acc(req_dst_acc),
        .req_cur(req_cur), .req_amount(req_amount),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_balance(rsp_balance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any response seen there
    task automatic tick();
        logic [3+BW:0] e;
        @(negedge clk);
        got_rsp = 1'b0;
        if (rsp_valid === 1'b1) begin
            got_rsp = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_status", 32'(rsp_status), 32'(e[3+BW:BW]));
                check("rsp_balance", 32'(rsp_balance), 32'(e[BW-1:0]));
            end
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [3:0] acc, input logic [3:0] dst,
                          input logic [2:0] cur, input logic [10:0] amt,
                          input logic [3:0] st, input logic [BW-1:0] bal);
        int n;
        int lat;
        exp_q.push_back({st, bal});
        req_op = op; req_acc = acc; req_dst_acc = dst; req_cur = cur; req_amount = amt;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_op      = 2'($urandom);
        req_acc     = 4'($urandom);
        req_dst_acc = 4'($urandom);
        req_cur     = 3'($urandom);
        req_amount  = 11'($urandom);
        lat = 0;
        got_rsp = 1'b0;
        while (!got_rsp && lat < 10) begin
            tick();
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'd3);
        tick();
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; req_valid = 1'b0; req_op = RD; req_acc = '0; req_dst_acc = '0;
        req_cur = '0; req_amount = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_status", 32'(rsp_status), 32'd0);
        check("rst_balance", 32'(rsp_balance), 32'd0);
        rst_n = 1'b1;
        tick();

        do_req(RD, 4'd3, 4'd0, 3'd0, 11'd0,    4'b0001, 11'd500);
        do_req(WD, 4'd2, 4'd0, 3'd0, 11'd500,  4'b0101, 11'd0);
        do_req(WD, 4'd2, 4'd0, 3'd0, 11'd1,    4'b0110, 11'd0);
        do_req(XF, 4'd1, 4'd4, 3'd2, 11'd7,    4'b0101, 11'd3);
        do_req(RD, 4'd4, 4'd0, 3'd2, 11'd0,    4'b0001, 11'd17);
        do_req(XF, 4'd1, 4'd1, 3'd2, 11'd1,    4'b1010, 11'd3);
        do_req(DP, 4'd0, 4'd0, 3'd0, 11'd1548, 4'b1001, 11'd500);
        do_req(DP, 4'd0, 4'd0, 3'd0, 11'd1547, 4'b0101, 11'd2047);
        do_req(XF, 4'd5, 4'd0, 3'd0, 11'd1,    4'b1001, 11'd500);
        do_req(XF, 4'd6, 4'd7, 3'd1, 11'd11,   4'b0110, 11'd10);
        do_req(XF, 4'd6, 4'd7, 3'd1, 11'd10,   4'b0101, 11'd0);
        do_req(RD, 4'd7, 4'd0, 3'd1, 11'd0,    4'b0001, 11'd20);
        do_req(RD, 4'd10, 4'd0, 3'd0, 11'd0,   4'b0010, 11'd0);
        do_req(RD, 4'd3, 4'd0, 3'd5, 11'd0,    4'b1011, 11'd0);
        do_req(XF, 4'd0, 4'd12, 3'd7, 11'd1,   4'b0010, 11'd0);
        do_req(XF, 4'd3, 4'd3, 3'd7, 11'd1,    4'b1011, 11'd0);
        do_req(XF, 4'd12, 4'd1, 3'd0, 11'd0,   4'b0010, 11'd0);
        do_req(DP, 4'd8, 4'd0, 3'd3, 11'd0,    4'b0101, 11'd10);
        do_req(WD, 4'd9, 4'd0, 3'd4, 11'd10,   4'b0101, 11'd0);
        do_req(RD, 4'd9, 4'd0, 3'd4, 11'd0,    4'b0001, 11'd0);

        // Continuous req_valid: handshakes only every fourth cycle
        for (int i = 0; i < 4; i++) exp_q.push_back({4'b0001, 11'd500});
        req_op = RD; req_acc = 4'd3; req_dst_acc = 4'd0; req_cur = 3'd0; req_amount = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            check("ready_pattern", 32'(req_ready), (i % 4 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        req_valid = 1'b0;
        repeat (8) tick();
        check("burst_drained", 32'(exp_q.size()), 32'd0);

        // Reset in COMMIT of a withdrawal: no response and no write
        req_op = WD; req_acc = 4'd6; req_cur = 3'd0; req_amount = 11'd100;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (got_rsp) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        do_req(RD, 4'd6, 4'd0, 3'd0, 11'd0, 4'b0001, 11'd500);
        do_req(RD, 4'd0, 4'd0, 3'd0, 11'd0, 4'b0001, 11'd500);
        do_req(RD, 4'd2, 4'd0, 3'd0, 11'd0, 4'b0001, 11'd500);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
